// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/load/exec/store sequencer around control_unit; SEQ_STEP_EN adds single-step input
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
`ifdef SEQ_STEP_EN
  input  logic        step,
`endif
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] cu_instr,
  output logic [15:0] cu_dat_a,
  output logic [15:0] cu_dat_d,
  output logic [15:0] cu_dat_dref_a,
  input  logic [15:0] cu_dat_r,
  input  logic        cu_a,
  input  logic        cu_d,
  input  logic        cu_dref_a,
  input  logic        cu_j,
  output logic [15:0] pc,
  output logic        busy
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, EXEC = 3'd3, STORE = 3'd4;
  logic [2:0] state;
  logic [15:0] a, d, ir, mdr, st_addr, st_data;
  logic start;
`ifdef SEQ_STEP_EN
  assign start = run | step;
`else
  assign start = run;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      a <= '0;
      d <= '0;
      ir <= '0;
      mdr <= '0;
      st_addr <= '0;
      st_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= FETCH;
        FETCH: if (imem_ack) begin
          ir <= imem_rdata;
          state <= imem_rdata[15] ? LOAD : EXEC;
        end
        LOAD: if (dmem_ack) begin
          mdr <= dmem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          if (cu_d) d <= cu_dat_r;
          if (cu_a) a <= cu_dat_r;
          // jump target and store address both use A from before this instruction's write
          pc <= cu_j ? a : pc + 16'd1;
          st_addr <= a;
          st_data <= cu_dat_r;
          state <= cu_dref_a ? STORE : (run ? FETCH : IDLE);
        end
        STORE: if (dmem_ack) state <= run ? FETCH : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign imem_req = state == FETCH;
  assign imem_addr = imem_req ? pc : '0;
  assign dmem_req = state == LOAD || state == STORE;
  assign dmem_we = state == STORE;
  assign dmem_addr = state == LOAD ? a : (state == STORE ? st_addr : '0);
  assign dmem_wdata = state == STORE ? st_data : '0;
  assign cu_instr = ir;
  assign cu_dat_a = a;
  assign cu_dat_d = d;
  assign cu_dat_dref_a = mdr;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench with a toy control unit and handshaking memory responders
module tb_cpu_sequencer;
  logic clk = 0, rst_n = 0, run = 0, step = 0;
  logic imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0, busy;
  logic [15:0] imem_addr, imem_rdata = 0, dmem_addr, dmem_wdata, dmem_rdata = 0, pc;
  logic [15:0] cu_instr, cu_dat_a, cu_dat_d, cu_dat_dref_a, cu_dat_r;
  logic cu_a, cu_d, cu_dref_a, cu_j;
  int passed = 0, total = 0;

  cpu_sequencer #(.RESET_PC(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .cu_instr(cu_instr), .cu_dat_a(cu_dat_a), .cu_dat_d(cu_dat_d), .cu_dat_dref_a(cu_dat_dref_a),
    .cu_dat_r(cu_dat_r), .cu_a(cu_a), .cu_d(cu_d), .cu_dref_a(cu_dref_a), .cu_j(cu_j),
    .pc(pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // toy control unit: bit15=0 loads immediate into A; else [14]=A [13]=D [12]=*A [11]=jump,
  // op[1:0]: 0 *A, 1 D+1, 2 ~D, 3 A
  always_comb begin
    cu_dat_r = cu_instr;
    cu_a = !cu_instr[15];
    cu_d = 0;
    cu_dref_a = 0;
    cu_j = 0;
    if (cu_instr[15]) begin
      cu_a = cu_instr[14];
      cu_d = cu_instr[13];
      cu_dref_a = cu_instr[12];
      cu_j = cu_instr[11];
      cu_dat_r = cu_instr[1:0] == 2'd0 ? cu_dat_dref_a :
                 cu_instr[1:0] == 2'd1 ? cu_dat_d + 16'd1 :
                 cu_instr[1:0] == 2'd2 ? ~cu_dat_d : cu_dat_a;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] instr);
    int n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    chk("imem_req", 16'(imem_req), 16'd1);
    chk("imem_addr", imem_addr, exp_addr);
    imem_rdata = instr;
    imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    imem_rdata = 16'hDEAD;
  endtask

  task automatic load(input logic [15:0] exp_addr, input logic [15:0] data);
    int n = 0;
    while (!dmem_req && n < 20) begin @(negedge clk); n++; end
    chk("load_req", 16'(dmem_req), 16'd1);
    chk("load_we", 16'(dmem_we), 16'd0);
    chk("load_addr", dmem_addr, exp_addr);
    dmem_rdata = data;
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    dmem_rdata = 16'hBEEF;
  endtask

  task automatic store(input logic [15:0] exp_addr, input logic [15:0] exp_data, input int dly, input bit drop_run);
    int n = 0;
    while (!dmem_req && n < 20) begin @(negedge clk); n++; end
    chk("store_req", 16'(dmem_req), 16'd1);
    chk("store_we", 16'(dmem_we), 16'd1);
    chk("store_addr", dmem_addr, exp_addr);
    chk("store_wdata", dmem_wdata, exp_data);
    if (drop_run) run = 0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("store_hold_req", 16'(dmem_req), 16'd1);
      chk("store_hold_addr", dmem_addr, exp_addr);
      chk("store_hold_wdata", dmem_wdata, exp_data);
    end
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_imem_req", 16'(imem_req), 16'd0);
    chk("rst_dmem_req", 16'(dmem_req), 16'd0);
    chk("rst_pc", pc, 16'h0100);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_a", cu_dat_a, 16'h0000);
    rst_n = 1;
    run = 1;
    // immediate load
    fetch(16'h0100, 16'h0005);
    chk("imm_no_dmem", 16'(dmem_req), 16'd0);
    chk("imm_busy", 16'(busy), 16'd1);
    @(negedge clk);
    chk("imm_a", cu_dat_a, 16'h0005);
    chk("imm_d", cu_dat_d, 16'h0000);
    chk("imm_pc", pc, 16'h0101);
    // D = *A
    fetch(16'h0101, 16'h0010);
    fetch(16'h0102, 16'hA000);
    load(16'h0010, 16'h0007);
    @(negedge clk);
    chk("ld_d", cu_dat_d, 16'h0007);
    chk("ld_a", cu_dat_a, 16'h0010);
    chk("ld_pc", pc, 16'h0103);
    // *A = D+1 with delayed store ack
    fetch(16'h0103, 16'h0002);
    fetch(16'h0104, 16'hA003);
    load(16'h0002, 16'h1234);
    fetch(16'h0105, 16'h0040);
    fetch(16'h0106, 16'h9001);
    load(16'h0040, 16'h5555);
    store(16'h0040, 16'h0003, 3, 0);
    chk("fetch_after_store", 16'(imem_req), 16'd1);
    chk("st_pc", pc, 16'h0107);
    // jumps use old A
    fetch(16'h0107, 16'h0123);
    fetch(16'h0108, 16'h8800);
    load(16'h0123, 16'h0000);
    fetch(16'h0123, 16'h0200);
    fetch(16'h0124, 16'hE801);
    load(16'h0200, 16'h0000);
    @(negedge clk);
    chk("jmp_pc", pc, 16'h0200);
    chk("jmp_a", cu_dat_a, 16'h0003);
    chk("jmp_d", cu_dat_d, 16'h0003);
    // PC wrap at FFFF and run dropped during store
    fetch(16'h0200, 16'h0000);
    fetch(16'h0201, 16'hA003);
    load(16'h0000, 16'h0000);
    fetch(16'h0202, 16'hC002);
    load(16'h0000, 16'h0000);
    fetch(16'h0203, 16'h8800);
    load(16'hFFFF, 16'h0000);
    fetch(16'hFFFF, 16'h9001);
    load(16'hFFFF, 16'h0000);
    store(16'hFFFF, 16'h0001, 2, 1);
    chk("wrap_pc", pc, 16'h0000);
    chk("stop_busy", 16'(busy), 16'd0);
    chk("stop_imem_req", 16'(imem_req), 16'd0);
    repeat (2) @(negedge clk);
    chk("idle_stays", 16'(busy), 16'd0);
    // async reset mid-fetch, late ack ignored
    run = 1;
    @(negedge clk);
    chk("pre_rst_req", 16'(imem_req), 16'd1);
    chk("pre_rst_addr", imem_addr, 16'h0000);
    #2 rst_n = 0;
    #1;
    chk("async_req", 16'(imem_req), 16'd0);
    chk("async_pc", pc, 16'h0100);
    chk("async_busy", 16'(busy), 16'd0);
    run = 0;
    @(negedge clk);
    rst_n = 1;
    imem_rdata = 16'h0005;
    imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    chk("late_ack_busy", 16'(busy), 16'd0);
    chk("late_ack_ir", cu_instr, 16'h0000);
    chk("late_ack_pc", pc, 16'h0100);
`ifdef SEQ_STEP_EN
    step = 1;
    @(negedge clk);
    step = 0;
    fetch(16'h0100, 16'h0042);
    @(negedge clk);
    chk("step_busy", 16'(busy), 16'd0);
    chk("step_a", cu_dat_a, 16'h0042);
    chk("step_pc", pc, 16'h0101);
    repeat (2) @(negedge clk);
    chk("step_once", 16'(busy), 16'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
